// File: rtl/gtx_link_init_ctrl.sv
// gtx_link_init_ctrl: GTX tile bring-up and per-lane 8b10b code-group sync controller.
// Sequences tile reset, waits for PLL lock and lane reset-done, restarts on timeout or
// lock loss, recovers RX elastic-buffer errors and tracks per-lane code-group sync.
// Ports:
//   CLK_IN, RESET_IN (async, active-high)
//   PLLLKDET_IN, RESETDONE_IN[N], RXBUFSTATUS_IN[3N], RXCHARISCOMMA_IN[N],
//   RXDISPERR_IN[N], RXNOTINTABLE_IN[N]                       - GTX status inputs
//   GTXRESET_OUT, RXBUFRESET_OUT[N], RXENCOMMAALIGN_OUT[N],
//   SYNC_OUT[N], TILE_READY_OUT, RESTART_CNT_OUT[8]             - registered outputs
// Optional: define CODE_ERR_COUNTERS_EN to add CNT_CLR_IN and CODE_ERR_CNT_OUT[16N],
// per-lane saturating invalid code-group counters.
module gtx_link_init_ctrl #(
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned GTXRESET_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT    = 1024,
  parameter int unsigned DONE_TIMEOUT    = 1024,
  parameter int unsigned BUFRESET_CYCLES = 4,
  parameter int unsigned SYNC_ACQ_COMMAS = 3,
  parameter int unsigned SYNC_LOSS_ERRS  = 4
) (
  input  logic                        CLK_IN,
  input  logic                        RESET_IN,
  input  logic                        PLLLKDET_IN,
  input  logic [NUM_CHANNELS-1:0]     RESETDONE_IN,
  input  logic [3*NUM_CHANNELS-1:0]   RXBUFSTATUS_IN,
  input  logic [NUM_CHANNELS-1:0]     RXCHARISCOMMA_IN,
  input  logic [NUM_CHANNELS-1:0]     RXDISPERR_IN,
  input  logic [NUM_CHANNELS-1:0]     RXNOTINTABLE_IN,
`ifdef CODE_ERR_COUNTERS_EN
  input  logic                        CNT_CLR_IN,
  output logic [16*NUM_CHANNELS-1:0]  CODE_ERR_CNT_OUT,
`endif
  output logic                        GTXRESET_OUT,
  output logic [NUM_CHANNELS-1:0]     RXBUFRESET_OUT,
  output logic [NUM_CHANNELS-1:0]     RXENCOMMAALIGN_OUT,
  output logic [NUM_CHANNELS-1:0]     SYNC_OUT,
  output logic                        TILE_READY_OUT,
  output logic [7:0]                  RESTART_CNT_OUT
);

  localparam int unsigned T_MAX0 = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned T_MAX  = (T_MAX0 > GTXRESET_CYCLES) ? T_MAX0 : GTXRESET_CYCLES;
  localparam int unsigned TCNT_W = $clog2(T_MAX + 1);
  localparam int unsigned BCNT_W = $clog2(BUFRESET_CYCLES + 1);
  localparam int unsigned CCNT_W = $clog2(SYNC_ACQ_COMMAS + 1);
  localparam int unsigned ERR_W  = $clog2(SYNC_LOSS_ERRS + 1);

  typedef enum logic [1:0] {T_RST, T_WAIT_LOCK, T_WAIT_DONE, T_READY} tile_t;
  typedef enum logic [1:0] {L_LOSS, L_DET, L_ACQ} lane_t;

  tile_t                    r_tstate;
  logic [TCNT_W-1:0]        r_tcnt;
  logic                     r_gtxreset;
  logic                     r_tile_ready;
  logic [7:0]               r_restart_cnt;

  lane_t                    r_lstate [NUM_CHANNELS];
  logic [CCNT_W-1:0]        r_ccnt   [NUM_CHANNELS];
  logic [ERR_W-1:0]         r_err    [NUM_CHANNELS];
  logic [1:0]               r_good   [NUM_CHANNELS];
  logic [BCNT_W-1:0]        r_bcnt   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  r_bufrst;
  logic [NUM_CHANNELS-1:0]  r_align;
  logic [NUM_CHANNELS-1:0]  r_sync;

  logic                     w_all_done;
  logic                     w_restart;
  logic                     w_ready_hold;
  logic [NUM_CHANNELS-1:0]  w_inv;
  logic [NUM_CHANNELS-1:0]  w_comma;
  logic                     w_unused;

  assign w_all_done   = &RESETDONE_IN;
  assign w_inv        = RXDISPERR_IN | RXNOTINTABLE_IN;
  assign w_comma      = RXCHARISCOMMA_IN & ~w_inv;
  // Only the overflow/underflow bit of each lane's buffer status is acted on.
  assign w_unused     = ^RXBUFSTATUS_IN;
  // Lanes only run while the tile stays READY through this edge.
  assign w_ready_hold = (r_tstate == T_READY) && PLLLKDET_IN && w_all_done;

  // Conditions that send the tile back to RST (and count a restart).
  always_comb begin
    w_restart = 1'b0;
    case (r_tstate)
      T_WAIT_LOCK: w_restart = !PLLLKDET_IN && (r_tcnt == TCNT_W'(LOCK_TIMEOUT - 1));
      T_WAIT_DONE: w_restart = !PLLLKDET_IN ||
                               (!w_all_done && (r_tcnt == TCNT_W'(DONE_TIMEOUT - 1)));
      T_READY:     w_restart = !PLLLKDET_IN || !w_all_done;
      default:     w_restart = 1'b0;
    endcase
  end

  // Tile bring-up FSM.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_tstate      <= T_RST;
      r_tcnt        <= '0;
      r_gtxreset    <= 1'b1;
      r_tile_ready  <= 1'b0;
      r_restart_cnt <= '0;
    end else if (w_restart) begin
      r_tstate     <= T_RST;
      r_tcnt       <= '0;
      r_gtxreset   <= 1'b1;
      r_tile_ready <= 1'b0;
      if (r_restart_cnt != 8'hFF) r_restart_cnt <= r_restart_cnt + 8'd1;
    end else begin
      case (r_tstate)
        T_RST: begin
          if (r_tcnt == TCNT_W'(GTXRESET_CYCLES - 1)) begin
            r_tstate   <= T_WAIT_LOCK;
            r_tcnt     <= '0;
            r_gtxreset <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        T_WAIT_LOCK: begin
          if (PLLLKDET_IN) begin
            r_tstate <= T_WAIT_DONE;
            r_tcnt   <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        T_WAIT_DONE: begin
          if (w_all_done) begin
            r_tstate     <= T_READY;
            r_tcnt       <= '0;
            r_tile_ready <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        T_READY: r_tcnt <= '0;
        default: begin
          r_tstate   <= T_RST;
          r_tcnt     <= '0;
          r_gtxreset <= 1'b1;
        end
      endcase
    end
  end

  // Per-lane buffer recovery and code-group sync FSM.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_bufrst <= '0;
      r_align  <= '0;
      r_sync   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_lstate[i] <= L_LOSS;
        r_ccnt[i]   <= '0;
        r_err[i]    <= '0;
        r_good[i]   <= '0;
        r_bcnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!w_ready_hold) begin
          r_lstate[i] <= L_LOSS;
          r_bufrst[i] <= 1'b0;
          r_bcnt[i]   <= '0;
          r_align[i]  <= 1'b0;
          r_sync[i]   <= 1'b0;
        end else if (r_bufrst[i]) begin
          // Pulse in progress: re-triggers ignored, lane held in LOSS.
          r_lstate[i] <= L_LOSS;
          r_align[i]  <= 1'b1;
          r_sync[i]   <= 1'b0;
          if (r_bcnt[i] == BCNT_W'(BUFRESET_CYCLES - 1)) r_bufrst[i] <= 1'b0;
          else                                           r_bcnt[i]   <= r_bcnt[i] + 1'b1;
        end else if (RXBUFSTATUS_IN[3*i+2]) begin
          r_bufrst[i] <= 1'b1;
          r_bcnt[i]   <= '0;
          r_lstate[i] <= L_LOSS;
          r_align[i]  <= 1'b1;
          r_sync[i]   <= 1'b0;
        end else begin
          case (r_lstate[i])
            L_LOSS: begin
              r_align[i] <= 1'b1;
              r_sync[i]  <= 1'b0;
              if (w_comma[i]) begin
                r_lstate[i] <= L_DET;
                r_ccnt[i]   <= CCNT_W'(1);
              end
            end
            L_DET: begin
              r_align[i] <= 1'b1;
              r_sync[i]  <= 1'b0;
              if (w_inv[i]) begin
                r_lstate[i] <= L_LOSS;
              end else if (w_comma[i]) begin
                if (r_ccnt[i] == CCNT_W'(SYNC_ACQ_COMMAS - 1)) begin
                  r_lstate[i] <= L_ACQ;
                  r_err[i]    <= '0;
                  r_good[i]   <= '0;
                  r_align[i]  <= 1'b0;
                  r_sync[i]   <= 1'b1;
                end else begin
                  r_ccnt[i] <= r_ccnt[i] + 1'b1;
                end
              end
            end
            L_ACQ: begin
              if (w_inv[i]) begin
                r_good[i] <= '0;
                if (r_err[i] == ERR_W'(SYNC_LOSS_ERRS - 1)) begin
                  r_lstate[i] <= L_LOSS;
                  r_align[i]  <= 1'b1;
                  r_sync[i]   <= 1'b0;
                end else begin
                  r_err[i] <= r_err[i] + 1'b1;
                end
              end else if (r_err[i] != '0) begin
                // Four consecutive good code-groups forgive one error.
                if (r_good[i] == 2'd3) begin
                  r_err[i]  <= r_err[i] - 1'b1;
                  r_good[i] <= '0;
                end else begin
                  r_good[i] <= r_good[i] + 2'd1;
                end
              end else if (r_good[i] != 2'd3) begin
                r_good[i] <= r_good[i] + 2'd1;
              end
            end
            default: r_lstate[i] <= L_LOSS;
          endcase
        end
      end
    end
  end

`ifdef CODE_ERR_COUNTERS_EN
  logic [15:0] r_errcnt [NUM_CHANNELS];

  // Saturating invalid code-group counters; clear wins over increment.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_errcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (CNT_CLR_IN)                                                 r_errcnt[i] <= '0;
        else if ((r_tstate == T_READY) && w_inv[i] && (r_errcnt[i] != 16'hFFFF)) r_errcnt[i] <= r_errcnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt_out
    assign CODE_ERR_CNT_OUT[16*g +: 16] = r_errcnt[g];
  end
`endif

  assign GTXRESET_OUT       = r_gtxreset;
  assign RXBUFRESET_OUT     = r_bufrst;
  assign RXENCOMMAALIGN_OUT = r_align;
  assign SYNC_OUT           = r_sync;
  assign TILE_READY_OUT     = r_tile_ready;
  assign RESTART_CNT_OUT    = r_restart_cnt;

endmodule

// File: tb/tb_gtx_link_init_ctrl.sv
// Directed bench for gtx_link_init_ctrl: bring-up, lane sync vectors, buffer recovery,
// lock loss, lock timeout with restart-count saturation, optional error counters.
module tb_gtx_link_init_ctrl;

  localparam int unsigned N      = 2;
  localparam int unsigned T_LOCK = 128;
  localparam int unsigned T_DONE = 64;

  logic         clk;
  logic         rst;
  logic         pll;
  logic [N-1:0] done;
  logic [3*N-1:0] bufst;
  logic [N-1:0] comma;
  logic [N-1:0] disp;
  logic [N-1:0] nit;
  logic         gtxreset;
  logic [N-1:0] bufrst;
  logic [N-1:0] align;
  logic [N-1:0] sync;
  logic         ready;
  logic [7:0]   restart_cnt;
`ifdef CODE_ERR_COUNTERS_EN
  logic         cnt_clr;
  logic [16*N-1:0] code_err_cnt;
`endif

  gtx_link_init_ctrl #(
    .NUM_CHANNELS (N),
    .LOCK_TIMEOUT (T_LOCK),
    .DONE_TIMEOUT (T_DONE)
  ) dut (
    .CLK_IN             (clk),
    .RESET_IN           (rst),
    .PLLLKDET_IN        (pll),
    .RESETDONE_IN       (done),
    .RXBUFSTATUS_IN     (bufst),
    .RXCHARISCOMMA_IN   (comma),
    .RXDISPERR_IN       (disp),
    .RXNOTINTABLE_IN    (nit),
`ifdef CODE_ERR_COUNTERS_EN
    .CNT_CLR_IN         (cnt_clr),
    .CODE_ERR_CNT_OUT   (code_err_cnt),
`endif
    .GTXRESET_OUT       (gtxreset),
    .RXBUFRESET_OUT     (bufrst),
    .RXENCOMMAALIGN_OUT (align),
    .SYNC_OUT           (sync),
    .TILE_READY_OUT     (ready),
    .RESTART_CNT_OUT    (restart_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] comma;
    logic [1:0] disp;
    logic [1:0] nit;
    logic [5:0] bufst;
    logic [1:0] e_sync;
    logic [1:0] e_align;
    logic [1:0] e_bufrst;
  } vec_t;

  vec_t vt[$];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic vec_t mk(input logic [1:0] c, input logic [1:0] d, input logic [1:0] n,
                              input logic [5:0] b, input logic [1:0] s, input logic [1:0] a,
                              input logic [1:0] r);
    vec_t v;
    v.comma = c; v.disp = d; v.nit = n; v.bufst = b;
    v.e_sync = s; v.e_align = a; v.e_bufrst = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for GTXRESET to drop and then rise again, within cycle budgets.
  task automatic wait_rise(output bit ok);
    int k;
    k = 0;
    while (gtxreset === 1'b1 && k < 50) begin tick(); k++; end
    k = 0;
    while (gtxreset !== 1'b1 && k < 300) begin tick(); k++; end
    ok = (gtxreset === 1'b1);
  endtask

  initial begin
    bit ok;
    bit all_ok;
    int k;

    // Lane-0 sync vectors; lane 1 idles in LOSS until the joint acquire at the end.
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00)); // comma 1
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00)); // comma 2
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00)); // comma 3 -> ACQ
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00)); // err1
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00)); // err2
    vt.push_back(mk(2'b01, 2'b01, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00)); // comma+disp: err3
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00)); // err4 -> LOSS
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00)); // DET
    vt.push_back(mk(2'b00, 2'b00, 2'b01, 6'o00, 2'b00, 2'b11, 2'b00)); // invalid in DET -> LOSS
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00)); // ACQ
    for (int i = 0; i < 3; i++)  vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    for (int i = 0; i < 12; i++) vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    for (int i = 0; i < 3; i++)  vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b01, 2'b10, 2'b00));
    vt.push_back(mk(2'b00, 2'b01, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00)); // 4th -> LOSS
    vt.push_back(mk(2'b11, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b11, 2'b00, 2'b00, 6'o00, 2'b00, 2'b11, 2'b00));
    vt.push_back(mk(2'b11, 2'b00, 2'b00, 6'o00, 2'b11, 2'b00, 2'b00)); // both lanes ACQ
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o05, 2'b10, 2'b01, 2'b01)); // lane0 buffer error
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b10, 2'b01, 2'b01));
    vt.push_back(mk(2'b00, 2'b00, 2'b00, 6'o04, 2'b10, 2'b01, 2'b01)); // re-trigger ignored
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b10, 2'b01, 2'b01));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b10, 2'b01, 2'b00)); // last pulse edge
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b10, 2'b01, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b10, 2'b01, 2'b00));
    vt.push_back(mk(2'b01, 2'b00, 2'b00, 6'o00, 2'b11, 2'b00, 2'b00)); // re-acquired

    rst = 1'b1; pll = 1'b0; done = '0; bufst = '0; comma = '0; disp = '0; nit = '0;
`ifdef CODE_ERR_COUNTERS_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_gtxreset", 32'(gtxreset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_restart", 32'(restart_cnt), 32'd0);
    chk("rst_lanes", {26'd0, bufrst, align, sync}, 32'd0);
    rst = 1'b0;

    // Bring-up: lock at cycle 20, reset-done at cycle 40.
    for (int c = 0; c < 46; c++) begin
      pll  = (c >= 20);
      done = (c >= 40) ? 2'b11 : 2'b00;
      tick();
      chk($sformatf("bringup_gtxreset_c%0d", c), 32'(gtxreset), (c < 7) ? 32'd1 : 32'd0);
      chk($sformatf("bringup_ready_c%0d", c), 32'(ready), (c >= 40) ? 32'd1 : 32'd0);
    end
    chk("bringup_restart", 32'(restart_cnt), 32'd0);
    chk("bringup_align", 32'(align), 32'd3);
    chk("bringup_sync", 32'(sync), 32'd0);

    foreach (vt[i]) begin
      comma = vt[i].comma; disp = vt[i].disp; nit = vt[i].nit; bufst = vt[i].bufst;
      tick();
      chk($sformatf("vec%0d_sync", i), 32'(sync), 32'(vt[i].e_sync));
      chk($sformatf("vec%0d_align", i), 32'(align), 32'(vt[i].e_align));
      chk($sformatf("vec%0d_bufrst", i), 32'(bufrst), 32'(vt[i].e_bufrst));
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
    end
    comma = '0; disp = '0; nit = '0; bufst = '0;

`ifdef CODE_ERR_COUNTERS_EN
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    nit = 2'b10;
    repeat (5) tick();
    nit = 2'b00;
    tick();
    chk("errcnt_lane1", 32'(code_err_cnt[31:16]), 32'd5);
    chk("errcnt_lane0", 32'(code_err_cnt[15:0]), 32'd0);
    cnt_clr = 1'b1; nit = 2'b10;
    tick();
    cnt_clr = 1'b0; nit = 2'b00;
    chk("errcnt_clr", 32'(code_err_cnt), 32'd0);
`endif

    // Lock loss while READY.
    pll = 1'b0;
    tick();
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_sync", 32'(sync), 32'd0);
    chk("loss_gtxreset", 32'(gtxreset), 32'd1);
    chk("loss_restart", 32'(restart_cnt), 32'd1);

    // RST hold then exact lock timeout.
    repeat (7) tick();
    chk("hold_gtxreset_hi", 32'(gtxreset), 32'd1);
    tick();
    chk("hold_gtxreset_lo", 32'(gtxreset), 32'd0);
    repeat (T_LOCK - 1) tick();
    chk("timeout_before", 32'(gtxreset), 32'd0);
    chk("timeout_before_cnt", 32'(restart_cnt), 32'd1);
    tick();
    chk("timeout_gtxreset", 32'(gtxreset), 32'd1);
    chk("timeout_restart", 32'(restart_cnt), 32'd2);

    // Remaining timeouts (300 in total) must saturate the counter.
    all_ok = 1'b1;
    for (int n = 0; n < 299; n++) begin
      wait_rise(ok);
      if (!ok) all_ok = 1'b0;
    end
    chk("sat_waits", 32'(all_ok), 32'd1);
    chk("sat_restart", 32'(restart_cnt), 32'd255);

    // Recovery back to READY.
    pll = 1'b1; done = 2'b11;
    k = 0;
    while (ready !== 1'b1 && k < 500) begin tick(); k++; end
    chk("recover_ready", 32'(ready), 32'd1);
    chk("recover_restart", 32'(restart_cnt), 32'd255);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_gtxreset", 32'(gtxreset), 32'd1);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_restart", 32'(restart_cnt), 32'd0);
    chk("arst_lanes", {26'd0, bufrst, align, sync}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
